// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative shift-add multiplier, restoring divider and HI/LO registers.
// Single-cycle ops answer one cycle after accept; MULT/DIV hold in_ready low for WIDTH+1 cycles.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ealuc,
    input  logic [WIDTH-1:0] eqa,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] r,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpXor   = 4'b0011;
    localparam logic [3:0] OpSltu  = 4'b0100;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpMult  = 4'b1000;
    localparam logic [3:0] OpMultu = 4'b1001;
    localparam logic [3:0] OpDiv   = 4'b1010;
    localparam logic [3:0] OpDivu  = 4'b1011;
    localparam logic [3:0] OpNor   = 4'b1100;
    localparam logic [3:0] OpMfhi  = 4'b1101;
    localparam logic [3:0] OpMflo  = 4'b1110;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    // acc_hi/acc_lo: product halves for MUL, remainder/quotient for DIV
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;

    logic accept;
    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    // MULT and DIV (even codes) are the signed variants
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign signed_op = ~ealuc[0];
    assign mag_a     = (signed_op && eqa[WIDTH-1]) ? -eqa : eqa;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf, slt, sltu;
    assign sum     = eqa + b;
    assign diff    = eqa - b;
    assign add_ovf = (eqa[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != eqa[WIDTH-1]);
    assign sub_ovf = (eqa[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != eqa[WIDTH-1]);
    assign slt     = $signed(eqa) < $signed(b);
    assign sltu    = eqa < b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    logic [WIDTH:0]   div_sh, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_n, div_q_n;
    assign div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_sh - {1'b0, opnd_q};
    assign div_ge    = ~div_trial[WIDTH];
    assign div_rem_n = div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q_n   = {acc_lo_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               last;
    assign prod     = {mul_hi_n, mul_lo_n};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -div_q_n : div_q_n;
    assign rem_fix  = rneg_q ? -div_rem_n : div_rem_n;
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        r_d         = r_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (ealuc)
                        OpMult, OpMultu: begin
                            neg_d    = signed_op && (eqa[WIDTH-1] ^ b[WIDTH-1]);
                            acc_hi_d = '0;
                            acc_lo_d = mag_b;
                            opnd_d   = mag_a;
                            cnt_d    = '0;
                            state_d  = StMul;
                        end
                        OpDiv, OpDivu: begin
                            if (b == '0) begin
                                // No iteration: answer next cycle with the fixed pattern
                                hi_d        = eqa;
                                lo_d        = '1;
                                r_d         = '1;
                                ovf_d       = 1'b0;
                                dz_d        = 1'b1;
                                out_valid_d = 1'b1;
                                state_d     = StDone;
                            end else begin
                                neg_d    = signed_op && (eqa[WIDTH-1] ^ b[WIDTH-1]);
                                rneg_d   = signed_op && eqa[WIDTH-1];
                                acc_hi_d = '0;
                                acc_lo_d = mag_a;
                                opnd_d   = mag_b;
                                cnt_d    = '0;
                                state_d  = StDiv;
                            end
                        end
                        default: begin
                            out_valid_d = 1'b1;
                            ovf_d       = 1'b0;
                            dz_d        = 1'b0;
                            case (ealuc)
                                OpAnd:   r_d = eqa & b;
                                OpOr:    r_d = eqa | b;
                                OpXor:   r_d = eqa ^ b;
                                OpNor:   r_d = ~(eqa | b);
                                OpAdd: begin
                                    r_d   = sum;
                                    ovf_d = add_ovf;
                                end
                                OpSub: begin
                                    r_d   = diff;
                                    ovf_d = sub_ovf;
                                end
                                OpSlt:   r_d = {{(WIDTH-1){1'b0}}, slt};
                                OpSltu:  r_d = {{(WIDTH-1){1'b0}}, sltu};
                                OpMfhi:  r_d = hi_q;
                                OpMflo:  r_d = lo_q;
                                default: r_d = '0;
                            endcase
                        end
                    endcase
                end
            end
            StMul: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = prod_fix;
                    r_d          = prod_fix[WIDTH-1:0];
                    ovf_d        = 1'b0;
                    dz_d         = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = StDone;
                end
            end
            StDiv: begin
                acc_hi_d = div_rem_n;
                acc_lo_d = div_q_n;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    hi_d        = rem_fix;
                    lo_d        = quo_fix;
                    r_d         = quo_fix;
                    ovf_d       = 1'b0;
                    dz_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign r           = r_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: a driver pushes model results, a monitor pops them on out_valid.
module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ealuc = 4'd0;
    logic [W-1:0] eqa = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] r;
    logic         overflow;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ealuc(ealuc),
        .eqa(eqa), .b(b), .out_valid(out_valid), .r(r), .overflow(overflow),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r, hi, lo;
        logic        ovf, dz;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural meaning of each op
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] bb,
                                  output logic [31:0] res, output logic ovf, output logic dz,
                                  output int lat);
        longint sa, sb2, s, q, rm;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb2 = longint'($signed(bb));
        res = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
        case (op)
            4'b0000: res = a & bb;
            4'b0001: res = a | bb;
            4'b0011: res = a ^ bb;
            4'b1100: res = ~(a | bb);
            4'b0010, 4'b0110: begin
                s = (op == 4'b0010) ? sa + sb2 : sa - sb2;
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: res = (sa < sb2) ? 32'd1 : 32'd0;
            4'b0100: res = (a < bb) ? 32'd1 : 32'd0;
            4'b1101: res = m_hi;
            4'b1110: res = m_lo;
            4'b1000: begin
                s = sa * sb2;
                {m_hi, m_lo} = s;
                res = m_lo; lat = 33;
            end
            4'b1001: begin
                up = {32'd0, a} * {32'd0, bb};
                {m_hi, m_lo} = up;
                res = m_lo; lat = 33;
            end
            4'b1010, 4'b1011: begin
                if (bb == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a; dz = 1'b1;
                end else begin
                    lat = 33;
                    if (op == 4'b1011) begin
                        m_lo = a / bb; m_hi = a % bb;
                    end else if (a == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000; m_hi = 0;
                    end else begin
                        q = sa / sb2; rm = sa % sb2;
                        m_lo = q[31:0]; m_hi = rm[31:0];
                    end
                end
                res = m_lo;
            end
            default: res = '0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] bb);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; ealuc = op; eqa = a; b = bb;
        e.op = op;
        model(op, a, bb, e.r, e.ovf, e.dz, e.due);
        e.hi = m_hi; e.lo = m_lo;
        e.due += cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("r op=%b", e.op), r, e.r);
                check($sformatf("overflow op=%b", e.op), overflow, e.ovf);
                check($sformatf("div_by_zero op=%b", e.op), div_by_zero, e.dz);
                check($sformatf("hi op=%b", e.op), hi, e.hi);
                check($sformatf("lo op=%b", e.op), lo, e.lo);
                check($sformatf("latency op=%b", e.op), cyc, e.due);
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        mismatched++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] ops [16];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset r", r, 0);
        check("reset overflow", overflow, 0);
        check("reset div_by_zero", div_by_zero, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
        issue(4'b0110, 32'd5, 32'd7);
        issue(4'b0111, 32'hFFFF_FFFF, 32'h1);
        issue(4'b0100, 32'hFFFF_FFFF, 32'h1);
        issue(4'b1100, 32'h0, 32'h0);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(4'b1101, 32'h0, 32'h0);
        issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
        issue(4'b1011, 32'd100, 32'd7);
        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'b1011, 32'd42, 32'd0);
        issue(4'b1110, 32'h0, 32'h0);
        drain();

        for (int i = 0; i < 150; i++) begin
            issue(ops[$urandom_range(0, 15)], rnd_operand(), rnd_operand());
        end
        drain();

        // Abort a multiply with reset while a competing request is held high
        @(negedge clk);
        check("abort in_ready", in_ready, 1);
        in_valid = 1'b1; ealuc = 4'b1000; eqa = 32'h0000_1234; b = 32'h0000_5678;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ealuc = 4'b0010; eqa = 32'd1; b = 32'd1;
            check("busy in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort in_ready after rst", in_ready, 1);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort out_valid", out_valid, 0);
        repeat (40) @(negedge clk);
        check("abort no stray result", sb.size(), 0);

        issue(4'b0010, 32'd1, 32'd1);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
